mesm6_acc_seq: RTL and testbench

- Accumulator sequencer that sits directly upstream of the ALU. It owns the 48-bit accumulator register A.
- It accepts one decoded arithmetic/logical command at a time and obtains operand B, either as an immediate or via a memory read.
- It drives the ALU op/a/b inputs, waits for the ALU done flag, then writes the result back into A.
- It guarantees the ALU sees op == ALU_NOP for at least one cycle between consecutive operations, so the ALU done flag and cycle count clear.

---
 rtl/mesm6_acc_seq.sv | 144 ++++++++++++++
 tb/tb_mesm6_acc_seq.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesm6_acc_seq.sv
// Accumulator sequencer in front of the ALU: owns the 48-bit accumulator, fetches
// operand B (immediate or memory), runs one ALU operation and writes the result back.
module mesm6_acc_seq #(
   parameter int                    ADDR_WIDTH   = 15,
   parameter int                    MEM_TIMEOUT  = 15,
   parameter int                    ALU_OP_WIDTH = 4,
   parameter logic [ALU_OP_WIDTH-1:0] ALU_NOP    = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ALU_OP_WIDTH-1:0] cmd_op,
   input  logic                    cmd_wy,
   input  logic                    cmd_mem,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [47:0]             cmd_imm,
   output logic                    mem_req,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic                    mem_ack,
   input  logic [47:0]             mem_rdata,
   output logic [ALU_OP_WIDTH-1:0] alu_op,
   output logic                    alu_wy,
   output logic [47:0]             alu_a,
   output logic [47:0]             alu_b,
   input  logic [47:0]             alu_result,
   input  logic                    alu_done,
   output logic [47:0]             acc,
   output logic                    busy,
   output logic                    fault,
   output logic [2:0]              dbg_state
);

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // the producer must hold every cmd_* field stable while cmd_valid is high and
   // cmd_ready is low. cmd_ready is high exactly when the FSM sits in IDLE.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_WB    = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

   state_t                    state;
   state_t                    next_state;
   logic [ALU_OP_WIDTH-1:0]   op_q;
   logic [7:0]                tmo_cnt;
   logic                      tmo_hit;
   logic                      done_seen;

   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign alu_a     = acc;
   assign dbg_state = state;
   assign tmo_hit   = ((tmo_cnt + 8'd1) == TMO_LIMIT);
   // A done flag while the ALU is idle is a leftover from the previous op.
   assign done_seen = alu_done && (alu_op != ALU_NOP);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_op == ALU_NOP) next_state = S_GAP;
               else if (cmd_mem)      next_state = S_FETCH;
               else                   next_state = S_EXEC;
            end
         end
         S_FETCH: begin
            if (mem_ack)      next_state = S_EXEC;
            else if (tmo_hit) next_state = S_GAP;
         end
         S_EXEC:  if (done_seen) next_state = S_WB;
         S_WB:    next_state = S_IDLE;
         // A Y update spends its wy cycle here too, then one more quiet cycle.
         S_GAP:   if (!alu_wy) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         alu_op   <= ALU_NOP;
         alu_wy   <= 1'b0;
         alu_b    <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         fault    <= 1'b0;
         tmo_cnt  <= '0;
         op_q     <= ALU_NOP;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  fault <= 1'b0;
                  op_q  <= cmd_op;
                  if (cmd_op == ALU_NOP) begin
                     alu_wy <= cmd_wy;
                  end else if (cmd_mem) begin
                     mem_req  <= 1'b1;
                     mem_addr <= cmd_addr;
                     tmo_cnt  <= '0;
                  end else begin
                     alu_b  <= cmd_imm;
                     alu_op <= cmd_op;
                  end
               end
            end
            S_FETCH: begin
               if (mem_ack) begin
                  alu_b   <= mem_rdata;
                  mem_req <= 1'b0;
                  alu_op  <= op_q;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
                  if (tmo_hit) begin
                     mem_req <= 1'b0;
                     fault   <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               if (done_seen) begin
                  acc    <= alu_result;
                  alu_op <= ALU_NOP;
               end
            end
            S_GAP:   alu_wy <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mesm6_acc_seq.sv
// Directed bench for mesm6_acc_seq with a behavioural ALU, a memory responder
// and an expected-accumulator queue.
module tb_mesm6_acc_seq;

   localparam int AW  = 15;
   localparam int TMO = 15;
   localparam int OPW = 4;
   localparam logic [OPW-1:0] OP_NOP = 4'd0;
   localparam logic [OPW-1:0] OP_AND = 4'd1;
   localparam logic [OPW-1:0] OP_OR  = 4'd2;
   localparam logic [OPW-1:0] OP_XOR = 4'd3;
   localparam logic [OPW-1:0] OP_ACA = 4'd4;

   logic           clk = 1'b0;
   logic           reset;
   logic           cmd_valid;
   logic           cmd_ready;
   logic [OPW-1:0] cmd_op;
   logic           cmd_wy;
   logic           cmd_mem;
   logic [AW-1:0]  cmd_addr;
   logic [47:0]    cmd_imm;
   logic           mem_req;
   logic [AW-1:0]  mem_addr;
   logic           mem_ack;
   logic [47:0]    mem_rdata;
   logic [OPW-1:0] alu_op;
   logic           alu_wy;
   logic [47:0]    alu_a;
   logic [47:0]    alu_b;
   logic [47:0]    alu_result;
   logic           alu_done;
   logic [47:0]    acc;
   logic           busy;
   logic           fault;
   logic [2:0]     dbg_state;

   mesm6_acc_seq #(.ADDR_WIDTH(AW), .MEM_TIMEOUT(TMO), .ALU_OP_WIDTH(OPW), .ALU_NOP(OP_NOP)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_wy(cmd_wy), .cmd_mem(cmd_mem), .cmd_addr(cmd_addr),
      .cmd_imm(cmd_imm), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .alu_op(alu_op), .alu_wy(alu_wy), .alu_a(alu_a),
      .alu_b(alu_b), .alu_result(alu_result), .alu_done(alu_done), .acc(acc),
      .busy(busy), .fault(fault), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int op_starts = 0;
   logic [OPW-1:0] prev_op = OP_NOP;
   logic [47:0] exp_q[$];
   logic [47:0] model_acc;

   int          alu_lat = 1;
   int          alu_cnt;
   logic        force_done = 1'b0;
   int          mem_lat = 0;
   logic [47:0] mem_data = '0;
   int          req_cycles;
   logic        late_ack = 1'b0;

   int          busy_n, wy_n, req_n, addr_bad;
   logic [AW-1:0] exp_addr;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (alu_op != OP_NOP && prev_op == OP_NOP) op_starts++;
      prev_op = alu_op;
   end

   function automatic logic [47:0] ref_op(input logic [OPW-1:0] op, input logic [47:0] a,
                                          input logic [47:0] b);
      logic [48:0] s;
      case (op)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_ACA: begin
            s = {1'b0, a} + {1'b0, b};
            return s[47:0] + {47'd0, s[48]};
         end
         default: return a;
      endcase
   endfunction

   // Behavioural ALU: done rises alu_lat cycles after a non-NOP op appears, clears on NOP.
   initial begin
      alu_done = 1'b0; alu_result = '0; alu_cnt = 0;
      forever begin
         @(negedge clk);
         if (alu_op == OP_NOP) begin
            alu_cnt  = 0;
            alu_done = force_done;
            if (force_done) alu_result = 48'hDEAD_BEEF_0001;
         end else if (!alu_done) begin
            alu_cnt++;
            if (alu_cnt > alu_lat) begin
               alu_done   = 1'b1;
               alu_result = ref_op(alu_op, alu_a, alu_b);
            end
         end
      end
   end

   // Memory: acks mem_lat cycles into a request (never when mem_lat == 0).
   initial begin
      mem_ack = 1'b0; mem_rdata = '0; req_cycles = 0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (late_ack) begin
            mem_ack = 1'b1; mem_rdata = 48'h0BAD_0BAD_0BAD; late_ack = 1'b0;
         end else if (mem_req) begin
            req_cycles++;
            if (mem_lat != 0 && req_cycles == mem_lat) begin
               mem_ack = 1'b1; mem_rdata = mem_data;
            end
         end else begin
            req_cycles = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offers a command and holds it until the acceptance edge; returns #1 after that edge.
   task automatic issue(input logic [OPW-1:0] op, input logic wy, input logic mem,
                        input logic [AW-1:0] addr, input logic [47:0] imm);
      int n = 0;
      cmd_op = op; cmd_wy = wy; cmd_mem = mem; cmd_addr = addr; cmd_imm = imm;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 200) check("accept_timeout", 1, 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      busy_n = 0; wy_n = 0; req_n = 0; addr_bad = 0;
      while (!cmd_ready && busy_n < 200) begin
         if (alu_wy) wy_n++;
         if (mem_req) begin
            req_n++;
            if (mem_addr !== exp_addr) addr_bad++;
         end
         busy_n++;
         @(posedge clk); #1;
      end
      if (busy_n >= 200) check("idle_timeout", 1, 0);
   endtask

   task automatic push_result(input logic [OPW-1:0] op, input logic [47:0] b);
      model_acc = ref_op(op, model_acc, b);
      exp_q.push_back(model_acc);
   endtask

   task automatic pop_check(input string tag);
      if (exp_q.size() == 0) check({tag, "_queue_empty"}, 1, 0);
      else check(tag, acc, exp_q.pop_front());
   endtask

   int s0, t0, t1;

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_wy = 1'b0; cmd_mem = 1'b0;
      cmd_addr = '0; cmd_imm = '0; exp_addr = '0; model_acc = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_acc", acc, 0);
      check("rst_alu_op", alu_op, OP_NOP);
      check("rst_alu_wy", alu_wy, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_fault", fault, 0);
      check("rst_state", dbg_state, 0);
      check("rst_ready", cmd_ready, 1);
      reset = 1'b0;

      // AND immediate on zero accumulator, 1-cycle ALU
      alu_lat = 1;
      issue(OP_AND, 0, 0, '0, 48'hFFFF_0000_FFFF);
      push_result(OP_AND, 48'hFFFF_0000_FFFF);
      check("and_alu_b", alu_b, 48'hFFFF_0000_FFFF);
      wait_idle();
      check("and_ready_latency", busy_n, 3);
      check("and_op_nop", alu_op, OP_NOP);
      pop_check("and_acc");

      // preload 0xFF, then XOR from memory with a 3-cycle ack
      issue(OP_OR, 0, 0, '0, 48'h0000_0000_00FF);
      push_result(OP_OR, 48'h0000_0000_00FF);
      wait_idle();
      pop_check("or_acc");
      mem_lat = 3; mem_data = 48'h0000_0000_0F0F; exp_addr = 15'h1234;
      issue(OP_XOR, 0, 1, 15'h1234, 48'h1111_1111_1111);
      push_result(OP_XOR, 48'h0000_0000_0F0F);
      wait_idle();
      check("xor_addr_stable", addr_bad, 0);
      check("xor_req_cycles", req_n, 3);
      check("xor_latency", busy_n, 6);
      pop_check("xor_acc");

      // back-to-back end-around-carry adds with a 2-cycle ALU
      alu_lat = 2;
      issue(OP_OR, 0, 0, '0, 48'hFFFF_FFFF_FFFF);
      push_result(OP_OR, 48'hFFFF_FFFF_FFFF);
      wait_idle();
      pop_check("aca_preload");
      s0 = op_starts;
      issue(OP_ACA, 0, 0, '0, 48'd1);
      push_result(OP_ACA, 48'd1);
      t0 = cyc;
      issue(OP_ACA, 0, 0, '0, 48'd1);
      t1 = cyc;
      check("b2b_accept_gap", t1 - t0, 5);
      pop_check("aca_first_acc");
      push_result(OP_ACA, 48'd1);
      wait_idle();
      check("b2b_second_busy", busy_n, 4);
      pop_check("aca_second_acc");
      check("b2b_op_starts", op_starts - s0, 2);

      // NOP with a Y update
      s0 = op_starts;
      issue(OP_NOP, 1, 0, '0, 48'h1234_5678_9ABC);
      push_result(OP_NOP, 48'h0);
      wait_idle();
      check("wy_cycles", wy_n, 1);
      check("wy_busy", busy_n, 2);
      check("wy_no_op", op_starts - s0, 0);
      pop_check("wy_acc");

      // memory timeout, then a stray ack, then fault cleared by the next command
      mem_lat = 0; exp_addr = 15'h0042;
      issue(OP_XOR, 0, 1, 15'h0042, 48'h0);
      push_result(OP_NOP, 48'h0);
      wait_idle();
      check("tmo_req_cycles", req_n, TMO);
      check("tmo_busy", busy_n, TMO + 1);
      check("tmo_mem_req", mem_req, 0);
      check("tmo_fault", fault, 1);
      pop_check("tmo_acc");
      late_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("late_ack_acc", acc, model_acc);
      check("late_ack_state", dbg_state, 0);
      check("late_ack_fault_sticky", fault, 1);
      issue(OP_AND, 0, 0, '0, 48'hFFFF_FFFF_FFFF);
      push_result(OP_AND, 48'hFFFF_FFFF_FFFF);
      check("fault_cleared", fault, 0);
      wait_idle();
      pop_check("post_tmo_acc");

      // reset in the middle of a 2-cycle op; a late done must not land
      alu_lat = 2;
      issue(OP_OR, 0, 0, '0, 48'h5);
      check("exec_state", dbg_state, 2);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid_rst_acc", acc, 0);
      check("mid_rst_op", alu_op, OP_NOP);
      check("mid_rst_state", dbg_state, 0);
      force_done = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      force_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("late_done_acc", acc, 0);
      check("late_done_state", dbg_state, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
